// File: rtl/alu_pkg.sv
// Shared constants for the Mini-ALU: sequencer state codes, opcodes, default widths.
// Latency: none (package only).
// Backpressure: none (package only).
package alu_pkg;

  localparam int DATA_W_DEF      = 6;
  localparam int OP_W_DEF        = 3;
  localparam int RES_W_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int STATE_W         = 3;

  // Sequencer state codes; 6 and 7 are unused and recover to WAIT_A.
  localparam logic [STATE_W-1:0] WAIT_A  = 3'd0;
  localparam logic [STATE_W-1:0] WAIT_B  = 3'd1;
  localparam logic [STATE_W-1:0] WAIT_OP = 3'd2;
  localparam logic [STATE_W-1:0] EXEC    = 3'd3;
  localparam logic [STATE_W-1:0] CAPTURE = 3'd4;
  localparam logic [STATE_W-1:0] SHOW    = 3'd5;

  // Opcodes understood by the combinational ALU.
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_LESS = 3'b100;
  localparam logic [2:0] OP_GTE  = 3'b101;

endpackage

// File: rtl/btn_sync_edge.sv
// Pushbutton synchroniser plus rising-edge detector, one-cycle pulse per press.
// Latency: pulse is high in the cycle after SYNC_STAGES edges have seen the press.
// Backpressure: none; a held button yields a single pulse, release is required.
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2  // must be at least 2 for metastability settling
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the raw button through the synchroniser and remember the last output.
  // Everything resets high so a button held through reset is not seen as a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects A, B and opcode from shared switches on load presses, holds them for the ALU, registers the result.
// Latency: press acted on SYNC_STAGES+1 clocks after the button rises; result_valid 2 clocks after opcode latch.
// Backpressure: presses landing in EXEC or CAPTURE are dropped, never queued.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int OP_W        = OP_W_DEF,
  parameter int RES_W       = RES_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_btn,
  input  logic [DATA_W-1:0]  sw_data,
  input  logic [OP_W-1:0]    sw_op,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [OP_W-1:0]    alu_op,
  input  logic [RES_W-1:0]   alu_result,
  output logic [RES_W-1:0]   result,
  output logic               result_valid,
  output logic [2:0]         state_dbg
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;
  logic               w_load_pulse;
  logic               w_ld_a;
  logic               w_ld_b;
  logic               w_ld_op;
  logic               w_capture;
  logic [DATA_W-1:0]  r_alu_a;
  logic [DATA_W-1:0]  r_alu_b;
  logic [OP_W-1:0]    r_alu_op;
  logic [RES_W-1:0]   r_result;
  logic               r_result_valid;

  btn_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_load_sync (
    .clk     (clk),
    .rst     (reset),
    .i_btn   (load_btn),
    .o_pulse (w_load_pulse)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= WAIT_A;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: entry states advance on a press, EXEC/CAPTURE are single fixed cycles.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT_A:  if (w_load_pulse) w_state_nxt = WAIT_B;
      WAIT_B:  if (w_load_pulse) w_state_nxt = WAIT_OP;
      WAIT_OP: if (w_load_pulse) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = CAPTURE;
      CAPTURE: w_state_nxt = SHOW;
      SHOW:    if (w_load_pulse) w_state_nxt = WAIT_B;
      default: w_state_nxt = WAIT_A;
    endcase
  end

  // Load enables; a press in SHOW is the A entry of the next operation.
  always_comb begin
    w_ld_a    = 1'b0;
    w_ld_b    = 1'b0;
    w_ld_op   = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      WAIT_A:  w_ld_a    = w_load_pulse;
      WAIT_B:  w_ld_b    = w_load_pulse;
      WAIT_OP: w_ld_op   = w_load_pulse;
      CAPTURE: w_capture = 1'b1;
      SHOW:    w_ld_a    = w_load_pulse;
      default: ;
    endcase
  end

  // Operand/result registers; each changes only on its own load cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alu_a        <= '0;
      r_alu_b        <= '0;
      r_alu_op       <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      if (w_ld_a)  r_alu_a  <= sw_data;
      if (w_ld_b)  r_alu_b  <= sw_data;
      if (w_ld_op) r_alu_op <= sw_op;
      if (w_capture) begin
        r_result       <= alu_result;
        r_result_valid <= 1'b1;
      end else if (w_ld_a) begin
        // Starting a new operation; the old result stays on display but is no longer valid.
        r_result_valid <= 1'b0;
      end
    end
  end

  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign alu_op       = r_alu_op;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign state_dbg    = r_state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for the operand sequencer with an 8-bit signed ALU model closing the loop.
// Latency: n/a.
// Backpressure: n/a.
module tb_alu_operand_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_btn;
  logic [5:0] sw_data;
  logic [2:0] sw_op;
  logic [5:0] alu_a;
  logic [5:0] alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_result;
  logic [7:0] result;
  logic       result_valid;
  logic [2:0] state_dbg;

  int n_pass  = 0;
  int n_total = 0;

  // Expected outputs, tracked per operation entry.
  logic [5:0] m_a, m_b;
  logic [2:0] m_op;
  logic [7:0] m_res;
  logic       m_vld;
  logic [2:0] m_st;

  alu_operand_sequencer #(
    .DATA_W(6), .OP_W(3), .RES_W(8), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .load_btn(load_btn), .sw_data(sw_data), .sw_op(sw_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .result(result), .result_valid(result_valid), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(input logic [5:0] a, input logic [5:0] b, input logic [2:0] op);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      OP_ADD:  alu_fn = 8'(sa + sb);
      OP_SUB:  alu_fn = 8'(sa - sb);
      OP_AND:  alu_fn = 8'(sa & sb);
      OP_OR:   alu_fn = 8'(sa | sb);
      OP_LESS: alu_fn = (sa <  sb) ? 8'd1 : 8'd0;
      OP_GTE:  alu_fn = (sa >= sb) ? 8'd1 : 8'd0;
      default: alu_fn = 8'd0;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_a, alu_b, alu_op);

  function automatic logic [26:0] obs();
    obs = {alu_a, alu_b, alu_op, result, result_valid, state_dbg};
  endfunction

  function automatic logic [26:0] expv();
    expv = {m_a, m_b, m_op, m_res, m_vld, m_st};
  endfunction

  task automatic model_clear();
    m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_vld = 1'b0; m_st = WAIT_A;
  endtask

  // Which entry a press fills depends only on how many entries the user has made.
  task automatic model_press(input logic [5:0] d, input logic [2:0] op);
    if (m_st == WAIT_A || m_st == SHOW) begin
      m_a = d; m_vld = 1'b0; m_st = WAIT_B;
    end else if (m_st == WAIT_B) begin
      m_b = d; m_st = WAIT_OP;
    end else if (m_st == WAIT_OP) begin
      m_op = op; m_st = EXEC;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  // Raise the button; returns at the negedge after the edge where the press takes effect.
  task automatic press(input logic [5:0] d, input logic [2:0] op);
    @(negedge clk);
    sw_data  = d;
    sw_op    = op;
    load_btn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_press(d, op);
  endtask

  task automatic release_btn();
    load_btn = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // One full operation: three entries, then EXEC, CAPTURE and SHOW on consecutive cycles.
  task automatic run_op(input string name, input logic [5:0] a, input logic [5:0] b, input logic [2:0] op);
    logic [2:0] st_seq [3];
    st_seq[0] = EXEC; st_seq[1] = CAPTURE; st_seq[2] = SHOW;
    press(a, 3'd0);
    n_total++;
    if (obs() !== expv()) $display("FAIL %s_a got=%h exp=%h", name, obs(), expv()); else n_pass++;
    release_btn();
    press(b, 3'd0);
    n_total++;
    if (obs() !== expv()) $display("FAIL %s_b got=%h exp=%h", name, obs(), expv()); else n_pass++;
    release_btn();
    press(6'd0, op);
    for (int k = 0; k < 3; k++) begin
      m_st = st_seq[k];
      if (k == 2) begin
        m_res = alu_fn(m_a, m_b, m_op);
        m_vld = 1'b1;
      end
      n_total++;
      if (obs() !== expv()) $display("FAIL %s_step%0d got=%h exp=%h", name, k, obs(), expv()); else n_pass++;
      if (k < 2) @(negedge clk);
    end
    release_btn();
  endtask

  task automatic test_reset();
    load_btn = 1'b0;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i % 5 == 4) begin
        n_total++;
        if (obs() !== expv()) $display("FAIL reset_idle got=%h exp=%h", obs(), expv()); else n_pass++;
      end
    end
    load_btn = 1'b1;
    apply_reset();
    repeat (20) @(negedge clk);
    n_total++;
    if (obs() !== expv()) $display("FAIL reset_btn_held got=%h exp=%h", obs(), expv()); else n_pass++;
    load_btn = 1'b0;
    repeat (5) @(negedge clk);
    n_total++;
    if (obs() !== expv()) $display("FAIL reset_btn_release got=%h exp=%h", obs(), expv()); else n_pass++;
  endtask

  task automatic test_full_sequence();
    run_op("less", 6'b111011, 6'b000011, OP_LESS);
    n_total++;
    if ({alu_a, alu_b, alu_op, result, result_valid, state_dbg} !== {6'h3B, 6'h03, 3'b100, 8'h01, 1'b1, 3'd5})
      $display("FAIL less_const got=%h", obs());
    else n_pass++;
  endtask

  task automatic test_signed_add();
    run_op("add_pos", 6'b011111, 6'b000001, OP_ADD);
    n_total++;
    if (result !== 8'h20) $display("FAIL add_pos_const got=%h exp=20", result); else n_pass++;
    run_op("add_neg", 6'b100000, 6'b111111, OP_ADD);
    n_total++;
    if (result !== 8'hDF) $display("FAIL add_neg_const got=%h exp=df", result); else n_pass++;
  endtask

  task automatic test_restart();
    logic [7:0] prev_res;
    prev_res = result;
    press(6'h05, 3'd0);
    n_total++;
    if ({alu_a, result_valid, state_dbg, result} !== {6'h05, 1'b0, 3'd1, prev_res})
      $display("FAIL restart got=%h exp=%h", {alu_a, result_valid, state_dbg, result}, {6'h05, 1'b0, 3'd1, prev_res});
    else n_pass++;
    release_btn();
    press(6'h02, 3'd0);
    release_btn();
    press(6'd0, OP_SUB);
    repeat (2) @(negedge clk);
    m_st = SHOW; m_res = alu_fn(m_a, m_b, m_op); m_vld = 1'b1;
    n_total++;
    if (obs() !== expv()) $display("FAIL restart_finish got=%h exp=%h", obs(), expv()); else n_pass++;
    release_btn();
  endtask

  // Two presses are at least two cycles apart, so the closest stray press to an opcode
  // entry is one cycle-bounce later, landing in CAPTURE; it must be dropped, not queued.
  task automatic test_ignored_pulse();
    press(6'h11, 3'd0); release_btn();
    press(6'h2E, 3'd0); release_btn();
    @(negedge clk); sw_op = OP_OR; load_btn = 1'b1;
    @(negedge clk); load_btn = 1'b0;
    @(negedge clk); load_btn = 1'b1;
    @(negedge clk); load_btn = 1'b0;
    model_press(6'd0, OP_OR);
    n_total++;
    if (obs() !== expv()) $display("FAIL ign_exec got=%h exp=%h", obs(), expv()); else n_pass++;
    @(negedge clk);
    m_st = CAPTURE;
    n_total++;
    if (obs() !== expv()) $display("FAIL ign_capture got=%h exp=%h", obs(), expv()); else n_pass++;
    @(negedge clk);
    m_st = SHOW; m_res = alu_fn(m_a, m_b, m_op); m_vld = 1'b1;
    n_total++;
    if (obs() !== expv()) $display("FAIL ign_show got=%h exp=%h", obs(), expv()); else n_pass++;
    repeat (8) @(negedge clk);
    n_total++;
    if (obs() !== expv()) $display("FAIL ign_no_queue got=%h exp=%h", obs(), expv()); else n_pass++;
  endtask

  // Glitches entirely between clock edges are never sampled.
  task automatic test_glitch();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #2 load_btn = 1'b1;
      #2 load_btn = 1'b0;
    end
    repeat (6) @(negedge clk);
    n_total++;
    if (obs() !== expv()) $display("FAIL glitch got=%h exp=%h", obs(), expv()); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 15; i++) begin
      run_op("rand", 6'($urandom), 6'($urandom), 3'($urandom_range(0, 7)));
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    press(6'h2A, 3'd0); release_btn();
    press(6'h13, 3'd0); release_btn();
    n_total++;
    if ({alu_a, state_dbg} !== {6'h2A, 3'd2}) $display("FAIL mid_setup got=%h exp=%h", {alu_a, state_dbg}, {6'h2A, 3'd2}); else n_pass++;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    model_clear();
    n_total++;
    if (obs() !== expv()) $display("FAIL mid_async_reset got=%h exp=%h", obs(), expv()); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (obs() !== expv()) $display("FAIL mid_after_reset got=%h exp=%h", obs(), expv()); else n_pass++;
  endtask

  initial begin
    reset    = 1'b1;
    load_btn = 1'b0;
    sw_data  = '0;
    sw_op    = '0;
    model_clear();
    test_reset();
    test_full_sequence();
    test_signed_add();
    test_restart();
    test_ignored_pulse();
    test_glitch();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard bound in case a task stalls.
  initial begin
    #500000;
    $display("FAIL timeout got=stalled exp=finished");
    $fatal(1);
  end

endmodule
